// File: rtl/uba_intr_pkg.sv
// Shared types and helpers for the Unibus adapter interrupt controller.
package uba_intr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StIack,
    StVread,
    StVhold,
    StGuard
  } state_e;

  localparam int unsigned TimerW = 8;

  function automatic int unsigned slot_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uba_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module uba_prio_enc #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/uba_intr_ctrl.sv
// Unibus adapter interrupt controller: arbitrates device requests, runs the
// acknowledge and vector-read handshake, and returns the vector to the CPU.
module uba_intr_ctrl
  import uba_intr_pkg::*;
#(
  parameter int unsigned NDEV  = 4,
  parameter int unsigned VW    = 16,
  parameter int unsigned TMO   = 255,
  parameter int unsigned GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [NDEV-1:0]         devINTR,
  output logic [NDEV-1:0]         devIACK,
  output logic [NDEV-1:0]         vectREAD,
  input  logic [VW-1:0]           vectDATA,
  input  logic                    vectACK,
  output logic                    cpuINTR,
  output logic [slot_w(NDEV)-1:0] cpuSLOT,
  input  logic                    cpuACK,
  output logic [VW-1:0]           cpuVECT,
  output logic                    cpuVECTVLD,
  output logic                    vectERR
);

  localparam int unsigned SW = slot_w(NDEV);
  localparam logic [TimerW-1:0] TmoLast   = TimerW'(TMO - 1);
  localparam logic [TimerW-1:0] GuardLast = TimerW'(GUARD - 1);

  state_e              state_q;
  logic [SW-1:0]       sel_q;
  logic [SW-1:0]       cpu_slot_q;
  logic                cpu_intr_q;
  logic [NDEV-1:0]     dev_iack_q;
  logic [NDEV-1:0]     vect_read_q;
  logic [VW-1:0]       vect_q;
  logic                vect_vld_q;
  logic                vect_err_q;
  logic [TimerW-1:0]   cnt_q;

  logic                win_vld;
  logic [SW-1:0]       win_idx;

  uba_prio_enc #(
    .N  (NDEV),
    .IW (SW)
  ) u_prio_enc (
    .req_i   (devINTR),
    .valid_o (win_vld),
    .idx_o   (win_idx)
  );

  function automatic logic [NDEV-1:0] onehot(logic [SW-1:0] idx);
    logic [NDEV-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cpu_slot_q  <= '0;
      cpu_intr_q  <= 1'b0;
      dev_iack_q  <= '0;
      vect_read_q <= '0;
      vect_q      <= '0;
      vect_vld_q  <= 1'b0;
      vect_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else if (clr) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cpu_slot_q  <= '0;
      cpu_intr_q  <= 1'b0;
      dev_iack_q  <= '0;
      vect_read_q <= '0;
      vect_q      <= '0;
      vect_vld_q  <= 1'b0;
      vect_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      dev_iack_q <= '0;
      vect_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_vld) begin
            state_q    <= StReq;
            cpu_intr_q <= 1'b1;
            cpu_slot_q <= win_idx;
          end
        end
        StReq: begin
          if (!win_vld) begin
            state_q    <= StIdle;
            cpu_intr_q <= 1'b0;
          end else begin
            cpu_slot_q <= win_idx;
            if (cpuACK) begin
              sel_q      <= win_idx;
              dev_iack_q <= onehot(win_idx);
              cpu_intr_q <= 1'b0;
              state_q    <= StIack;
            end
          end
        end
        StIack: begin
          vect_read_q <= onehot(sel_q);
          cnt_q       <= '0;
          state_q     <= StVread;
        end
        StVread: begin
          if (vectACK) begin
            vect_q     <= vectDATA;
            vect_vld_q <= 1'b1;
            state_q    <= StVhold;
          end else if (cnt_q == TmoLast) begin
            vect_q     <= '0;
            vect_vld_q <= 1'b1;
            vect_err_q <= 1'b1;
            state_q    <= StVhold;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StVhold: begin
          if (!cpuACK) begin
            vect_read_q <= '0;
            vect_vld_q  <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StGuard;
          end
        end
        StGuard: begin
          // The last guard cycle doubles as the idle arbitration slot, so the
          // strobe stays low for exactly GUARD cycles before a new request.
          if (cnt_q == GuardLast) begin
            cnt_q <= '0;
            if (win_vld) begin
              state_q    <= StReq;
              cpu_intr_q <= 1'b1;
              cpu_slot_q <= win_idx;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign devIACK    = dev_iack_q;
  assign vectREAD   = vect_read_q;
  assign cpuINTR    = cpu_intr_q;
  assign cpuSLOT    = cpu_slot_q;
  assign cpuVECT    = vect_q;
  assign cpuVECTVLD = vect_vld_q;
  assign vectERR    = vect_err_q;

endmodule

// File: tb/tb_uba_intr_ctrl.sv
// Directed bench for uba_intr_ctrl: handshake, arbitration, timeout, guard, reset.
module tb_uba_intr_ctrl;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [3:0]  devINTR;
  logic [3:0]  devIACK;
  logic [3:0]  vectREAD;
  logic [15:0] vectDATA;
  logic        vectACK;
  logic        cpuINTR;
  logic [1:0]  cpuSLOT;
  logic        cpuACK;
  logic [15:0] cpuVECT;
  logic        cpuVECTVLD;
  logic        vectERR;

  int total = 0;
  int bad   = 0;

  uba_intr_ctrl #(
    .NDEV  (4),
    .VW    (16),
    .TMO   (255),
    .GUARD (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .devINTR    (devINTR),
    .devIACK    (devIACK),
    .vectREAD   (vectREAD),
    .vectDATA   (vectDATA),
    .vectACK    (vectACK),
    .cpuINTR    (cpuINTR),
    .cpuSLOT    (cpuSLOT),
    .cpuACK     (cpuACK),
    .cpuVECT    (cpuVECT),
    .cpuVECTVLD (cpuVECTVLD),
    .vectERR    (vectERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; devINTR = '0; vectDATA = '0; vectACK = 1'b0; cpuACK = 1'b0;
    #12;
    total++;
    if ({devIACK, vectREAD, cpuINTR, cpuSLOT, cpuVECT, cpuVECTVLD, vectERR} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%0h exp=0",
                      {devIACK, vectREAD, cpuINTR, cpuSLOT, cpuVECT, cpuVECTVLD, vectERR});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    devINTR = 4'b0100;
    step();
    total++;
    if ({cpuINTR, cpuSLOT} !== 3'b110) begin
      bad++; $display("FAIL basic_req got=%b exp=110", {cpuINTR, cpuSLOT});
    end
    step(); step();
    cpuACK = 1'b1;
    step();
    total++;
    if ({devIACK, vectREAD, cpuINTR} !== 9'b0100_0000_0) begin
      bad++; $display("FAIL basic_iack got=%b exp=010000000", {devIACK, vectREAD, cpuINTR});
    end
    step();
    total++;
    if ({devIACK, vectREAD} !== 8'b0000_0100) begin
      bad++; $display("FAIL basic_vread got=%b exp=00000100", {devIACK, vectREAD});
    end
    vectDATA = 16'o340; vectACK = 1'b1;
    step();
    total++;
    if ({cpuVECT, cpuVECTVLD, vectERR, vectREAD} !== {16'o340, 2'b10, 4'b0100}) begin
      bad++; $display("FAIL basic_vect got=%0h exp=%0h", {cpuVECT, cpuVECTVLD, vectERR, vectREAD},
                      {16'o340, 2'b10, 4'b0100});
    end
    vectACK = 1'b0; devINTR = '0;
    step();
    total++;
    if ({cpuVECTVLD, vectREAD} !== 5'b1_0100) begin
      bad++; $display("FAIL basic_vhold got=%b exp=10100", {cpuVECTVLD, vectREAD});
    end
    cpuACK = 1'b0;
    step();
    total++;
    if ({cpuVECTVLD, vectREAD} !== 5'b0) begin
      bad++; $display("FAIL basic_release got=%b exp=00000", {cpuVECTVLD, vectREAD});
    end
    repeat (4) step();
    total++;
    if (cpuINTR !== 1'b0) begin
      bad++; $display("FAIL basic_idle got=%b exp=0", cpuINTR);
    end
  endtask

  task automatic test_replace();
    devINTR = 4'b1000;
    step();
    total++;
    if ({cpuINTR, cpuSLOT} !== 3'b111) begin
      bad++; $display("FAIL replace_slot3 got=%b exp=111", {cpuINTR, cpuSLOT});
    end
    devINTR = 4'b1001;
    step();
    total++;
    if ({cpuINTR, cpuSLOT} !== 3'b100) begin
      bad++; $display("FAIL replace_slot0 got=%b exp=100", {cpuINTR, cpuSLOT});
    end
    cpuACK = 1'b1;
    step();
    total++;
    if (devIACK !== 4'b0001) begin
      bad++; $display("FAIL replace_iack got=%b exp=0001", devIACK);
    end
    step();
    total++;
    if (vectREAD !== 4'b0001) begin
      bad++; $display("FAIL replace_vread got=%b exp=0001", vectREAD);
    end
    vectDATA = 16'o300; vectACK = 1'b1;
    step();
    total++;
    if ({cpuVECT, cpuVECTVLD} !== {16'o300, 1'b1}) begin
      bad++; $display("FAIL replace_vect got=%0h exp=%0h", {cpuVECT, cpuVECTVLD}, {16'o300, 1'b1});
    end
    vectACK = 1'b0; devINTR = '0; cpuACK = 1'b0;
    step();
    repeat (4) step();
  endtask

  task automatic test_withdraw();
    devINTR = 4'b0010;
    step();
    total++;
    if ({cpuINTR, cpuSLOT} !== 3'b101) begin
      bad++; $display("FAIL withdraw_req got=%b exp=101", {cpuINTR, cpuSLOT});
    end
    devINTR = '0;
    step();
    total++;
    if (cpuINTR !== 1'b0) begin
      bad++; $display("FAIL withdraw_drop got=%b exp=0", cpuINTR);
    end
    cpuACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({devIACK, vectREAD, cpuINTR} !== 9'b0) begin
        bad++; $display("FAIL withdraw_quiet got=%b exp=0", {devIACK, vectREAD, cpuINTR});
      end
    end
    cpuACK = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int  rd_cycles;
    bit  seen;
    devINTR = 4'b0001;
    step();
    cpuACK = 1'b1;
    step();
    devINTR = '0;
    rd_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (cpuVECTVLD) seen = 1'b1;
      else if (vectREAD == 4'b0001) rd_cycles++;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL timeout_wait got=no_vld exp=vld_within_400");
    end
    total++;
    if (rd_cycles !== 255) begin
      bad++; $display("FAIL timeout_len got=%0d exp=255", rd_cycles);
    end
    total++;
    if ({vectERR, cpuVECT, vectREAD} !== {1'b1, 16'h0, 4'b0001}) begin
      bad++; $display("FAIL timeout_err got=%0h exp=%0h", {vectERR, cpuVECT, vectREAD},
                      {1'b1, 16'h0, 4'b0001});
    end
    step();
    total++;
    if ({vectERR, cpuVECTVLD} !== 2'b01) begin
      bad++; $display("FAIL timeout_pulse got=%b exp=01", {vectERR, cpuVECTVLD});
    end
    cpuACK = 1'b0;
    step();
    total++;
    if ({cpuVECTVLD, vectREAD} !== 5'b0) begin
      bad++; $display("FAIL timeout_release got=%b exp=0", {cpuVECTVLD, vectREAD});
    end
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    int  low_cycles;
    bit  seen;
    devINTR = 4'b0010;
    step();
    cpuACK = 1'b1;
    step(); step();
    vectDATA = 16'o320; vectACK = 1'b1;
    step();
    vectACK = 1'b0;
    total++;
    if ({cpuVECT, cpuVECTVLD} !== {16'o320, 1'b1}) begin
      bad++; $display("FAIL b2b_vect got=%0h exp=%0h", {cpuVECT, cpuVECTVLD}, {16'o320, 1'b1});
    end
    cpuACK = 1'b0;
    low_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (cpuINTR) seen = 1'b1;
      else if (vectREAD == 4'b0 && devIACK == 4'b0) low_cycles++;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL b2b_wait got=no_intr exp=intr_within_20");
    end
    total++;
    if (low_cycles !== 4) begin
      bad++; $display("FAIL b2b_guard got=%0d exp=4", low_cycles);
    end
    total++;
    if ({cpuSLOT, vectREAD} !== 6'b01_0000) begin
      bad++; $display("FAIL b2b_rearb got=%b exp=010000", {cpuSLOT, vectREAD});
    end
  endtask

  task automatic test_reset_clr();
    cpuACK = 1'b1;
    step();
    total++;
    if (devIACK !== 4'b0010) begin
      bad++; $display("FAIL rst_iack got=%b exp=0010", devIACK);
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({devIACK, vectREAD, cpuINTR, cpuSLOT, cpuVECT, cpuVECTVLD, vectERR} !== '0) begin
      bad++; $display("FAIL rst_async got=%0h exp=0",
                      {devIACK, vectREAD, cpuINTR, cpuSLOT, cpuVECT, cpuVECTVLD, vectERR});
    end
    devINTR = '0; cpuACK = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    devINTR = 4'b0100;
    step();
    cpuACK = 1'b1;
    step(); step();
    vectDATA = 16'o354; vectACK = 1'b1;
    step();
    vectACK = 1'b0;
    total++;
    if ({cpuVECTVLD, vectREAD} !== 5'b1_0100) begin
      bad++; $display("FAIL clr_pre got=%b exp=10100", {cpuVECTVLD, vectREAD});
    end
    clr = 1'b1;
    step();
    total++;
    if ({cpuVECTVLD, vectREAD, cpuINTR, cpuVECT} !== 22'b0) begin
      bad++; $display("FAIL clr_idle got=%0h exp=0", {cpuVECTVLD, vectREAD, cpuINTR, cpuVECT});
    end
    clr = 1'b0;
    step();
    total++;
    if ({cpuINTR, cpuSLOT} !== 3'b110) begin
      bad++; $display("FAIL clr_rearb got=%b exp=110", {cpuINTR, cpuSLOT});
    end
    devINTR = '0; cpuACK = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_replace();
    test_withdraw();
    test_timeout();
    test_back_to_back();
    test_reset_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
